// File: rtl/rtc_bus_write_cycle.sv
// rtc_bus_write_cycle
// Runs one complete write transaction on the RTC multiplexed address/data bus.
// The transaction has two phases. The address phase has a_d=0 and the data phase
// has a_d=1. Each phase is a setup/strobe/hold sequence. A cs_n-high gap sits
// between the two phases.
//
// Ports
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   start   in   request a write cycle; only looked at while idle
//   addr    in   [7:0] RTC register address, latched when start is accepted
//   data    in   [7:0] byte to write, latched when start is accepted
//   cs_n    out  RTC chip select, active low
//   rd_n    out  RTC read strobe, always high
//   wr_n    out  RTC write strobe, active low
//   a_d     out  0 = address phase, 1 = data phase / idle
//   ad_out  out  [7:0] byte for AD[7:0]
//   ad_oe   out  drive enable for AD[7:0]
//   busy    out  transaction in progress
//   done    out  one-cycle completion pulse
module rtc_bus_write_cycle #(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_WR    = 3,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        StIdle, StASetup, StAWr, StAHold, StGap, StDSetup, StDWr, StDHold, StFin
    } state_e;

    localparam logic [3:0] SetupLast = 4'(T_SETUP - 1);
    localparam logic [3:0] WrLast    = 4'(T_WR - 1);
    localparam logic [3:0] HoldLast  = 4'(T_HOLD - 1);
    localparam logic [3:0] GapLast   = 4'(T_GAP - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, data_q;
    logic       latch;

    logic       cs_n_d, wr_n_d, a_d_d, ad_oe_d, busy_d, done_d;
    logic [7:0] ad_out_d;

    // Next-state logic and per-state cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch   = 1'b1;
                    state_d = StASetup;
                end
            end
            StASetup: if (cnt_q == SetupLast) state_d = StAWr;
            StAWr:    if (cnt_q == WrLast)    state_d = StAHold;
            StAHold:  if (cnt_q == HoldLast)  state_d = StGap;
            StGap:    if (cnt_q == GapLast)   state_d = StDSetup;
            StDSetup: if (cnt_q == SetupLast) state_d = StDWr;
            StDWr:    if (cnt_q == WrLast)    state_d = StDHold;
            StDHold:  if (cnt_q == HoldLast)  state_d = StFin;
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Every state entry restarts the count; idle holds it at zero
        if (state_d != state_q || state_q == StIdle) begin
            cnt_d = 4'd0;
        end
    end

    // Pin values are decoded from the current state and registered, so the pins
    // follow the state register by one cycle. Every pin comes from a flop.
    always_comb begin
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        ad_out_d = 8'h00;
        unique case (state_q)
            StIdle: busy_d = 1'b0;
            StASetup, StAHold: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            StAWr: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            // Switch to the data byte while cs_n is high so AD is settled before the data phase
            StGap: begin
                ad_oe_d  = 1'b1;
                ad_out_d = data_q;
            end
            StDSetup, StDHold: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = data_q;
            end
            StDWr: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = data_q;
            end
            StFin:   done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b1;
            ad_out  <= 8'h00;
            ad_oe   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q <= addr;
                data_q <= data;
            end
            cs_n    <= cs_n_d;
            rd_n    <= 1'b1;
            wr_n    <= wr_n_d;
            a_d     <= a_d_d;
            ad_out  <= ad_out_d;
            ad_oe   <= ad_oe_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_write_cycle.sv
// Bench for rtc_bus_write_cycle. Two instances are driven by the same inputs.
// One uses the default timing. The other uses fast timing with T_WR=1 and T_GAP=1.
// The reference model builds a full expected pin timeline for each accepted
// write. It also pushes the expected transaction onto a scoreboard queue.
// A monitor compares the pins every cycle. It pops the queue on each done pulse.
module tb_rtc_bus_write_cycle;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         e;
    } txn_t;

    localparam logic [14:0] IdleVec = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    localparam int Depth = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data = 8'h00;

    logic       cs_n0, rd_n0, wr_n0, a_d0, ad_oe0, busy0, done0;
    logic       cs_n1, rd_n1, wr_n1, a_d1, ad_oe1, busy1, done1;
    logic [7:0] ad_out0, ad_out1;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    int ps[2] = '{1, 1};
    int pw[2] = '{3, 1};
    int ph[2] = '{1, 1};
    int pg[2] = '{2, 1};
    int free_e[2] = '{0, 0};

    logic [14:0] expv [2][Depth];
    logic [14:0] obs [2];
    txn_t sbq0[$];
    txn_t sbq1[$];

    rtc_bus_write_cycle u_def (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
        .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .a_d(a_d0), .ad_out(ad_out0),
        .ad_oe(ad_oe0), .busy(busy0), .done(done0)
    );

    rtc_bus_write_cycle #(.T_SETUP(1), .T_WR(1), .T_HOLD(1), .T_GAP(1)) u_fast (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
        .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .a_d(a_d1), .ad_out(ad_out1),
        .ad_oe(ad_oe1), .busy(busy1), .done(done1)
    );

    assign obs[0] = {cs_n0, rd_n0, wr_n0, a_d0, ad_oe0, busy0, done0, ad_out0};
    assign obs[1] = {cs_n1, rd_n1, wr_n1, a_d1, ad_oe1, busy1, done1, ad_out1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pins for transaction time slot t, where slot 0 is the first
    // slot after acceptance. The bit order is
    // {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, ad_out}.
    function automatic logic [14:0] gen(int t, int s, int w, int h, int g,
                                        logic [7:0] a, logic [7:0] d);
        logic cs, wr, ad, oe, dn;
        logic [7:0] o;
        int b1, b2, b3, b4, b5, b6;
        b1 = s + w;  b2 = b1 + h; b3 = b2 + g;
        b4 = b3 + s; b5 = b4 + w; b6 = b5 + h;
        cs = 1'b1; wr = 1'b1; ad = 1'b1; oe = 1'b1; dn = 1'b0; o = d;
        if (t < s)       begin cs = 1'b0; ad = 1'b0; o = a; end
        else if (t < b1) begin cs = 1'b0; wr = 1'b0; ad = 1'b0; o = a; end
        else if (t < b2) begin cs = 1'b0; ad = 1'b0; o = a; end
        else if (t < b3) begin end
        else if (t < b4) cs = 1'b0;
        else if (t < b5) begin cs = 1'b0; wr = 1'b0; end
        else if (t < b6) cs = 1'b0;
        else begin oe = 1'b0; dn = 1'b1; o = 8'h00; end
        return {cs, 1'b1, wr, ad, oe, 1'b1, dn, o};
    endfunction

    // Reference model for the edge about to sample the current inputs
    task automatic model_step();
        int e;
        int len;
        txn_t tx;
        e = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int k = e; k < e + 40; k++) expv[i][k] = IdleVec;
                if (i == 0) sbq0.delete(); else sbq1.delete();
                free_e[i] = e + 1;
            end else if (start && e >= free_e[i]) begin
                len = 2 * (ps[i] + pw[i] + ph[i]) + pg[i] + 1;
                for (int t = 0; t < len; t++)
                    expv[i][e + 1 + t] = gen(t, ps[i], pw[i], ph[i], pg[i], addr, data);
                tx.a = addr; tx.d = data; tx.e = e + len;
                if (i == 0) sbq0.push_back(tx); else sbq1.push_back(tx);
                free_e[i] = e + len + 1;
            end
        end
    endtask

    task automatic tick(input logic st, input logic [7:0] a, input logic [7:0] d,
                        input logic rst);
        @(negedge clk);
        start = st; addr = a; data = d; reset = rst;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: per-cycle pin comparison, invariants, and scoreboard on done
    logic [14:0] prev [2] = '{IdleVec, IdleVec};
    logic [7:0]  cap_a [2];
    logic [7:0]  cap_d [2];
    int          nlow_a [2] = '{0, 0};
    int          nlow_d [2] = '{0, 0};

    always @(posedge clk) begin
        int n;
        logic [14:0] ex;
        logic [14:0] ob;
        txn_t tx;
        int sz;
        #1;
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            ob = obs[i];
            ex = expv[i][n];
            // ad_out is don't-care in the completion slot because the bus is not driven
            if (ex[8]) begin
                ob[7:0] = 8'h00;
                ex[7:0] = 8'h00;
            end
            chk($sformatf("pins[%0d]@%0d", i, n), ob, ex);

            if (prev[i][12] && !obs[i][12]) begin
                chk($sformatf("wr_fall_glitch[%0d]", i), {13'd0, obs[i][14], obs[i][11]},
                    {13'd0, prev[i][14], prev[i][11]});
            end
            if (!prev[i][12] && !obs[i][12]) begin
                chk($sformatf("ad_stable_wr[%0d]", i), {7'd0, obs[i][7:0]},
                    {7'd0, prev[i][7:0]});
            end
            prev[i] = obs[i];

            if (reset) begin
                nlow_a[i] = 0; nlow_d[i] = 0;
            end else if (!obs[i][12]) begin
                if (!obs[i][11]) begin cap_a[i] = obs[i][7:0]; nlow_a[i]++; end
                else begin cap_d[i] = obs[i][7:0]; nlow_d[i]++; end
            end

            if (obs[i][8]) begin
                sz = (i == 0) ? sbq0.size() : sbq1.size();
                if (sz == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_done[%0d] at edge %0d: got done=1 expected none",
                             i, n);
                end else begin
                    if (i == 0) tx = sbq0.pop_front(); else tx = sbq1.pop_front();
                    chk($sformatf("done_edge[%0d]", i), 15'(n), 15'(tx.e));
                    chk($sformatf("wr_addr[%0d]", i), {7'd0, cap_a[i]}, {7'd0, tx.a});
                    chk($sformatf("wr_data[%0d]", i), {7'd0, cap_d[i]}, {7'd0, tx.d});
                    chk($sformatf("wr_len[%0d]", i), 15'({nlow_a[i][7:0], nlow_d[i][7:0]}),
                        15'({pw[i][7:0], pw[i][7:0]}));
                end
                nlow_a[i] = 0; nlow_d[i] = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < Depth; k++) expv[i][k] = IdleVec;

        // Reset held for 3 cycles
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #2;
        chk("reset_def", obs[0], IdleVec);
        chk("reset_fast", obs[1], IdleVec);

        // Single write, then a start at E5 that must be ignored
        tick(1'b1, 8'h21, 8'h45, 1'b0);
        idle(4);
        tick(1'b1, 8'hFF, 8'h99, 1'b0);
        idle(14);

        // Reset asserted at E9, during the data strobe of the default instance
        tick(1'b1, 8'h5A, 8'hC3, 1'b0);
        idle(8);
        tick(1'b0, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #2;
        chk("mid_reset_bus", {11'd0, wr_n0, cs_n0, ad_oe0, busy0}, {11'd0, 4'b1100});
        idle(2);
        tick(1'b1, 8'h33, 8'h77, 1'b0);
        idle(16);

        // start held high for 30 cycles back-to-back
        for (int k = 0; k < 30; k++) tick(1'b1, 8'h10, 8'h01, 1'b0);
        idle(16);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 99) == 0));
        end

        // Drain with a bounded wait
        for (int k = 0; k < 200 && (sbq0.size() != 0 || sbq1.size() != 0); k++) idle(1);
        checks++;
        if (sbq0.size() != 0 || sbq1.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", sbq0.size(), sbq1.size());
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
